// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - receiver FSM state type
//   - E0 / F0 prefix byte values
//   - bit offsets of the fields in the 64-bit kbin status word
//   - odd-parity helper for frame validation
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int unsigned KB_CODE_LSB   = 0;
  localparam int unsigned KB_BRK        = 8;
  localparam int unsigned KB_EXT        = 9;
  localparam int unsigned KB_EVCNT_LSB  = 16;
  localparam int unsigned KB_ERRCNT_LSB = 32;
  localparam int unsigned KB_VALID      = 63;

  // A PS/2 frame is good when data plus parity hold an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] dataByte, input logic parityBit);
    return ^{dataByte, parityBit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: two-flop synchroniser followed by a glitch filter for one
// raw PS/2 line. The filtered output changes only after FILTER_LEN consecutive
// synchronised samples disagree with it. Everything presets to 1 (idle bus).
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   lineRaw  in   raw line, asynchronous to clk
//   lineFilt out  synchronised and filtered line
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic lineRaw,
  output logic lineFilt
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] runCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      runCnt   <= '0;
      lineFilt <= 1'b1;
    end else begin
      sync1 <= lineRaw;
      sync2 <= sync1;
      // runCnt holds how many disagreeing samples preceded the current one.
      if (sync2 == lineFilt) begin
        runCnt <= '0;
      end else if (runCnt == CW'(FILTER_LEN - 1)) begin
        lineFilt <= sync2;
        runCnt   <= '0;
      end else begin
        runCnt <= runCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_in.sv
// ps2_kbd_in: PS/2 keyboard receiver producing the 64-bit kbin status word.
// Deframes 11-bit device-to-host frames, checks odd parity and the stop bit,
// folds E0/F0 prefixes into extended/break flags and counts events and errors.
// Optional macro PS2_KBD_FIFO_EN: published events are queued in a FIFO_DEPTH
// FIFO; kbin[9:0] shows the head, kbin[63] is "not empty", kb_pop dequeues.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   ps2_clk   in   raw PS/2 clock
//   ps2_data  in   raw PS/2 data
//   kb_pop    in   dequeue request (FIFO build only)
//   kbin      out  status word: code, break, extended, event/error counts, valid
//   key_event out  one-cycle pulse per published event
//   frame_err out  one-cycle pulse per frame error
module ps2_kbd_in #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        kb_pop,
  output logic [63:0] kbin,
  output logic        key_event,
  output logic        frame_err
);

  import ps2_pkg::*;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clkF;
  logic dataF;
  logic clkPrev;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilt (
    .clk      (clk),
    .reset    (reset),
    .lineRaw  (ps2_clk),
    .lineFilt (clkF)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilt (
    .clk      (clk),
    .reset    (reset),
    .lineRaw  (ps2_data),
    .lineFilt (dataF)
  );

  assign fall = clkPrev & ~clkF;

  ps2_state_e      state, stateNext;
  logic [2:0]      bitCnt, bitCntNext;
  logic [7:0]      shiftReg, shiftNext;
  logic            parBit, parNext;
  logic [WD_W-1:0] wdog, wdogNext;
  logic            extPend, extNext;
  logic            brkPend, brkNext;
  logic            pubNow;
  logic            errNow;
  logic            dropNow;
  logic [9:0]      evWord;
  logic [15:0]     evCnt;
  logic [7:0]      errCnt;
  logic [9:0]      headEv;
  logic            validBit;

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shiftNext  = shiftReg;
    parNext    = parBit;
    wdogNext   = '0;
    extNext    = extPend;
    brkNext    = brkPend;
    pubNow     = 1'b0;
    errNow     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (!dataF) begin
            stateNext  = DATA;
            bitCntNext = '0;
          end else begin
            errNow = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shiftNext = {dataF, shiftReg[7:1]};
          if (bitCnt == 3'd7) begin
            stateNext = PARITY;
          end else begin
            bitCntNext = bitCnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parNext   = dataF;
          stateNext = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          stateNext = IDLE;
          if (dataF && oddParityOk(shiftReg, parBit)) begin
            if (shiftReg == PS2_PREFIX_EXT) begin
              extNext = 1'b1;
            end else if (shiftReg == PS2_PREFIX_BRK) begin
              brkNext = 1'b1;
            end else begin
              pubNow  = 1'b1;
              extNext = 1'b0;
              brkNext = 1'b0;
            end
          end else begin
            errNow  = 1'b1;
            extNext = 1'b0;
            brkNext = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    // Watchdog only runs while a frame is open; an edge always takes priority.
    if (state != IDLE && !fall) begin
      if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
        stateNext = IDLE;
        errNow    = 1'b1;
        extNext   = 1'b0;
        brkNext   = 1'b0;
      end else begin
        wdogNext = wdog + WD_W'(1);
      end
    end
  end

  assign evWord = {extPend, brkPend, shiftReg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parBit    <= 1'b0;
      wdog      <= '0;
      extPend   <= 1'b0;
      brkPend   <= 1'b0;
      clkPrev   <= 1'b1;
      evCnt     <= '0;
      errCnt    <= '0;
      key_event <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftNext;
      parBit    <= parNext;
      wdog      <= wdogNext;
      extPend   <= extNext;
      brkPend   <= brkNext;
      clkPrev   <= clkF;
      key_event <= pubNow;
      frame_err <= errNow;
      if (pubNow) begin
        evCnt <= evCnt + 16'd1;
      end
      if ((errNow || dropNow) && errCnt != 8'hFF) begin
        errCnt <= errCnt + 8'd1;
      end
    end
  end

`ifdef PS2_KBD_FIFO_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [9:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   fifoCnt;
  logic             fifoFull;
  logic             popNow;
  logic             pushNow;

  assign fifoFull = (fifoCnt == (PTR_W + 1)'(FIFO_DEPTH));
  assign popNow   = kb_pop && (fifoCnt != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pushNow  = pubNow && (!fifoFull || popNow);
  assign dropNow  = pubNow && fifoFull && !popNow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (pushNow) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popNow) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (pushNow && !popNow) begin
        fifoCnt <= fifoCnt + (PTR_W + 1)'(1);
      end else if (popNow && !pushNow) begin
        fifoCnt <= fifoCnt - (PTR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushNow) begin
      fifoMem[wrPtr] <= evWord;
    end
  end

  assign validBit = (fifoCnt != '0);
  assign headEv   = validBit ? fifoMem[rdPtr] : '0;
`else
  logic [9:0] lastEv;
  logic       unusedPop;
  localparam int unsigned unusedDepth = FIFO_DEPTH;

  assign unusedPop = kb_pop;
  assign dropNow   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastEv   <= '0;
      validBit <= 1'b0;
    end else if (pubNow) begin
      lastEv   <= evWord;
      validBit <= 1'b1;
    end
  end

  assign headEv = lastEv;
`endif

  always_comb begin
    kbin                          = '0;
    kbin[KB_CODE_LSB +: 8]        = headEv[7:0];
    kbin[KB_BRK]                  = headEv[8];
    kbin[KB_EXT]                  = headEv[9];
    kbin[KB_EVCNT_LSB +: 16]      = evCnt;
    kbin[KB_ERRCNT_LSB +: 8]      = errCnt;
    kbin[KB_VALID]                = validBit;
  end

endmodule

// File: doc/ps2_kbd_in.md
Name: ps2_kbd_in

Overview:
- PS/2 keyboard receiver that produces the 64-bit `kbin` status word consumed by the CPU top level's data memory (keyboard input port).
- Synchronises and filters the PS/2 clock and data lines, deframes 11-bit device-to-host frames and checks parity.
- Folds E0/F0 prefix bytes into make/break and extended flags, and keeps event and error counters so software can poll `kbin` for changes.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before a filtered line changes value.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered ps2_clk falling edge, while a frame is open, before the frame is aborted.
- FIFO_DEPTH, 4: event FIFO depth, used only when PS2_KBD_FIFO_EN is defined; power of two.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- kb_pop  in  1  dequeue request; only has an effect with PS2_KBD_FIFO_EN.
- kbin  out  64  keyboard status word.
- key_event  out  1  one-cycle pulse when a key event is published.
- frame_err  out  1  one-cycle pulse on any frame error.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, prefix flags cleared, counters 0, kbin=64'h0, key_event=0, frame_err=0, filters preset to 1 (idle bus).
- Input conditioning: 2-flop synchroniser per line, then the FILTER_LEN filter.
  - A falling edge is the filtered ps2_clk going 1->0; all sampling of filtered ps2_data happens in that same cycle.
- FSM:
  - IDLE: on an edge, data=0 -> DATA with bit_cnt=0; data=1 -> stay IDLE, pulse frame_err, err_count++.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: publish when stop=1 and odd parity holds (ones in data+parity is odd). Otherwise pulse frame_err, err_count++, and clear both prefix flags. Always return to IDLE.
  - Timeout: in DATA, PARITY or STOP, if TIMEOUT_CYCLES pass with no edge -> IDLE, frame_err pulse, err_count++, prefix flags cleared. The watchdog counter resets on every edge.
- Byte handling (after a valid frame):
  - 8'hE0 sets ext_pend.
  - 8'hF0 sets brk_pend.
  - Prefix bytes publish nothing.
  - Any other byte (including 8'hE1) is published with the current flags; both flags are then cleared.
- Publish: kbin updates and key_event pulses in the clk cycle after the cycle in which the stop bit was sampled (latency 1). event_count++ on each publish.
- kbin layout:
  - [7:0] code.
  - [8] break.
  - [9] extended.
  - [15:10] 0.
  - [31:16] event_count: 16-bit, wraps 16'hFFFF->0.
  - [39:32] err_count: 8-bit, saturates at 8'hFF.
  - [62:40] 0.
  - [63] valid: set on the first publish, sticky until reset.
- Simultaneous events: a timeout and an edge in the same cycle -> the edge wins and there is no timeout. Reset mid-frame discards the partial frame with no error counted.

Optional Feature:
- PS2_KBD_FIFO_EN defined:
  - Published events (code, break, extended) enter a FIFO_DEPTH FIFO.
  - kbin[9:0] shows the FIFO head and kbin[63] = FIFO not empty.
  - kb_pop with the FIFO non-empty removes the head; kbin reflects the new head the next cycle.
  - Push to a full FIFO drops the event and counts err_count++ (event_count still increments).
  - Simultaneous push and pop on a full FIFO: both succeed.
- Undefined: no FIFO, kb_pop ignored, behaviour exactly as above (latest event, sticky valid).

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - kbin field offsets: KB_CODE_LSB=0, KB_BRK=8, KB_EXT=9, KB_EVCNT_LSB=16, KB_ERRCNT_LSB=32, KB_VALID=63.
- One sub-module, ps2_line_filter (synchroniser + FILTER_LEN filter), instantiated twice.

Test Plan:
- Frame 8'h1C, parity 0, stop 1 -> kbin[7:0]=8'h1C, [8]=0, [9]=0, [31:16]=1, [63]=1; key_event is 1 cycle high, 1 clk after the stop sample.
- Frames F0, 1C -> single publish with kbin[9:0]=10'h11C and event_count=1; then E0, F0, 75 -> kbin[9:0]=10'h375 and event_count=2.
- 8'h1C with parity=1 -> frame_err pulse, err_count=1, kbin code and event_count unchanged; a following F0/E0 state is cleared.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> err_count=1, FSM IDLE; a following valid 8'h29 frame is published correctly.
- reset pulled low mid-frame after 5 bits -> kbin=0 immediately; the next full 8'h1C frame gives event_count=1 and err_count=0.
- PS2_KBD_FIFO_EN: 5 events with no pop (depth 4) -> err_count=1 and the head is the first event; 4 pops give events 1..4 in order, then kbin[63]=0.
